mmss_countdown: RTL and testbench
=================================

MMSS_COUNTDOWN -- requirements
Module: mmss_countdown

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100000000, clock cycles per one-second countdown tick.
REQ-002 SHALL have parameter REFRESH_CYCLES, default 100000, clock cycles each display digit stays active.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse; begin or resume countdown.
REQ-006 SHALL have port stop  input  1  single-cycle pulse; abort countdown.
REQ-007 SHALL have port pause  input  1  single-cycle pulse; toggle RUN/PAUSED.
REQ-008 SHALL have port min  input  7  minutes preset, binary.
REQ-009 SHALL have port sec  input  7  seconds preset, binary.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the count reaches 00:00.
REQ-011 SHALL have port an  output  8  digit anodes, active-low.
REQ-012 SHALL have port dec_cat  output  8  segments, active-low: bit7..bit1 = a..g, bit0 = dp.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSED, DONE.
REQ-014 In IDLE, internal count SHALL load min/sec every cycle, min saturated to 99, sec saturated to 59.
REQ-015 IDLE + start with loaded count nonzero -> RUN next cycle, tick prescaler cleared to 0; count 00:00 -> stays IDLE.
REQ-016 In RUN, prescaler increments each cycle; at TICK_CYCLES-1 it wraps to 0 and issues one tick.
REQ-017 On tick: sec>0 -> sec-1; sec=0 and min>0 -> min-1, sec=59.
REQ-018 Tick that makes count 00:00 -> DONE next cycle; first decrement occurs TICK_CYCLES cycles after start.
REQ-019 DONE SHALL last exactly one cycle with done=1, then IDLE; done=0 in all other states.
REQ-020 RUN + pause -> PAUSED; count and prescaler frozen.
REQ-021 PAUSED + pause or start -> RUN; prescaler resumes from frozen value.
REQ-022 stop in RUN, PAUSED or DONE -> IDLE next cycle; count reloads from inputs; no done pulse.
REQ-023 Priority in the same cycle: stop > pause > start.
REQ-024 min/sec changes SHALL be ignored outside IDLE.
REQ-025 Display refresh counter SHALL free-run in all states, advancing digit index 0..3 every REFRESH_CYCLES cycles, wrapping 3->0.
REQ-026 Digit 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens; exactly one of an[3:0] low; an[7:4] always high.
REQ-027 Digits SHALL be decimal (0-9) derived from the current count; dp (dec_cat[0]) low only while digit 2 is active.
REQ-028 Segment encoding SHALL be standard 7-segment for 0-9; an and dec_cat SHALL be registered.
REQ-029 Total count SHALL never underflow below 00:00 nor exceed 99:59.

Reset
REQ-030 Reset SHALL force IDLE, count 00:00, prescaler 0, refresh counter 0, digit index 0, done=0.
REQ-031 During reset an = 8'hFF and dec_cat = 8'hFF; first digit driven on the first cycle after reset release.
REQ-032 Reset asserted mid-RUN SHALL abort immediately with no done pulse.

Verification (TICK_CYCLES=10, REFRESH_CYCLES=4)
REQ-033 min=0, sec=3, start pulse -> sec 2,1,0 at 10-cycle intervals; done high exactly one cycle; state IDLE after.
REQ-034 min=2, sec=0, start, one tick -> count 01:59; display digits 9,5,1,0 on an[0..3] low in turn, dp low with an[2].
REQ-035 start, pause after 5 cycles, hold 50 cycles, pause again -> first decrement 5 cycles after resume; no decrement while paused.
REQ-036 min=120, sec=75 in IDLE -> display shows 99:59; start with min=0, sec=0 -> stays IDLE, done never asserts.
REQ-037 stop and pause in same cycle during RUN -> IDLE, count reloads from inputs, done stays 0.
REQ-038 reset asserted mid-RUN at count 00:01 -> an=8'hFF, dec_cat=8'hFF, no done pulse, IDLE with 00:00 after release.

Source files
------------

// File: rtl/mmss_countdown.sv
// mmss_countdown -- MM:SS countdown timer with a four-digit multiplexed
// seven-segment display.
//
// Parameters
//   TICK_CYCLES    clock cycles per one-second countdown tick
//   REFRESH_CYCLES clock cycles each display digit stays lit
// Ports
//   clock    system clock, rising edge
//   reset    asynchronous, active-high
//   start    pulse: begin (from IDLE) or resume (from PAUSED)
//   stop     pulse: abort back to IDLE, count reloads from min/sec
//   pause    pulse: toggle RUN <-> PAUSED
//   min, sec preset in binary, sampled only while IDLE (saturated 99 / 59)
//   done     one-cycle pulse when the count reaches 00:00
//   an       digit anodes, active-low (an[7:4] unused, held high)
//   dec_cat  segments, active-low: [7:1] = a..g, [0] = dp
module mmss_countdown #(
  parameter int TICK_CYCLES    = 100000000,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [6:0] min,
  input  logic [6:0] sec,
  output logic       done,
  output logic [7:0] an,
  output logic [7:0] dec_cat
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t          state_q;
  logic [6:0]      min_q, sec_q;
  logic [PW-1:0]   presc_q;
  logic            done_q;
  logic [RW-1:0]   ref_q;
  logic [1:0]      digit_q;
  logic [7:0]      an_q, cat_q;

  // Presets clamped so the count can never exceed 99:59.
  logic [6:0] min_sat, sec_sat;
  logic       preset_nz;
  assign min_sat   = (min > 7'd99) ? 7'd99 : min;
  assign sec_sat   = (sec > 7'd59) ? 7'd59 : sec;
  assign preset_nz = (min_sat != 7'd0) || (sec_sat != 7'd0);

  // One-second decrement with borrow; holds at 00:00 so it cannot underflow.
  logic [6:0] min_dec, sec_dec;
  logic       dec_zero;
  always_comb begin
    min_dec = min_q;
    sec_dec = sec_q;
    if (sec_q != 7'd0) begin
      sec_dec = sec_q - 7'd1;
    end else if (min_q != 7'd0) begin
      min_dec = min_q - 7'd1;
      sec_dec = 7'd59;
    end
  end
  assign dec_zero = (min_dec == 7'd0) && (sec_dec == 7'd0);

  // Control FSM. Command priority within a cycle: stop > pause > start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      min_q   <= 7'd0;
      sec_q   <= 7'd0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          min_q <= min_sat;
          sec_q <= sec_sat;
          if (start && !stop && !pause && preset_nz) begin
            state_q <= RUN;
            presc_q <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            min_q   <= min_sat;
            sec_q   <= sec_sat;
          end else if (pause) begin
            state_q <= PAUSED;
          end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            min_q   <= min_dec;
            sec_q   <= sec_dec;
            if (dec_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        PAUSED: begin
          if (stop) begin
            state_q <= IDLE;
            min_q   <= min_sat;
            sec_q   <= sec_sat;
          end else if (pause || start) begin
            state_q <= RUN;
          end
        end
        DONE: begin
          // Exactly one cycle here; stop lands in the same place.
          state_q <= IDLE;
          min_q   <= min_sat;
          sec_q   <= sec_sat;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Active-low a..g for decimal digits; blank for anything else.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [3:0] digit_val;
  always_comb begin
    case (digit_q)
      2'd0:    digit_val = 4'(sec_q % 7'd10);
      2'd1:    digit_val = 4'(sec_q / 7'd10);
      2'd2:    digit_val = 4'(min_q % 7'd10);
      default: digit_val = 4'(min_q / 7'd10);
    endcase
  end

  // Free-running digit scan. Outputs are registered, so the digit shown
  // lags digit_q by one cycle and the first digit appears one cycle after
  // reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_q   <= '0;
      digit_q <= 2'd0;
      an_q    <= 8'hFF;
      cat_q   <= 8'hFF;
    end else begin
      if (ref_q == REF_MAX) begin
        ref_q   <= '0;
        digit_q <= digit_q + 2'd1;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
      an_q  <= {4'hF, ~(4'b0001 << digit_q)};
      // dp marks the MM.SS separator, lit with the minutes-units digit.
      cat_q <= {seg7(digit_val), (digit_q != 2'd2)};
    end
  end

  assign done    = done_q;
  assign an      = an_q;
  assign dec_cat = cat_q;

endmodule

// File: tb/tb_mmss_countdown.sv
module tb_mmss_countdown;
  localparam int TICK = 10;
  localparam int REF  = 4;

  logic       clock, reset, start, stop, pause;
  logic [6:0] min, sec;
  logic       done;
  logic [7:0] an, dec_cat;

  mmss_countdown #(.TICK_CYCLES(TICK), .REFRESH_CYCLES(REF)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .min(min), .sec(sec), .done(done), .an(an), .dec_cat(dec_cat)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Active-low a..g for 0-9.
  localparam logic [6:0] SEG [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [7:0] cat;
    string      nm;
  } dexp_t;

  dexp_t dq[$];     // expected display words, keyed by cycle
  int    doneq[$];  // expected cycles of done pulses
  int    cyc   = 0;
  int    tests = 0;
  int    fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: consumes expectations as the DUT presents them.
  always @(negedge clock) begin : mon
    dexp_t e;
    int    d;
    while (dq.size() > 0 && dq[0].cyc <= cyc) begin
      e = dq.pop_front();
      tests++;
      if (e.cyc != cyc || an !== e.an || dec_cat !== e.cat) begin
        fails++;
        $display("FAIL %s: an=%h dec_cat=%h at cycle %0d, want an=%h dec_cat=%h at cycle %0d",
                 e.nm, an, dec_cat, cyc, e.an, e.cat, e.cyc);
      end
    end
    if (done !== 1'b0) begin
      tests++;
      if (doneq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: done=%b at cycle %0d, want 0", done, cyc);
      end else begin
        d = doneq.pop_front();
        if (d != cyc || done !== 1'b1) begin
          fails++;
          $display("FAIL done_time: done=%b at cycle %0d, want 1 at cycle %0d", done, cyc, d);
        end
      end
    end
  end

  task automatic push_disp(input string nm, input logic [7:0] a, input logic [7:0] c);
    dexp_t e;
    e.cyc = cyc + 1;
    e.an  = a;
    e.cat = c;
    e.nm  = nm;
    dq.push_back(e);
  endtask

  task automatic pulse(input logic st, input logic sp, input logic pa);
    start = st; stop = sp; pause = pa;
    @(negedge clock);
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Waits for each digit to come round on the scan and queues what it
  // must show. Count must be stable (IDLE or PAUSED) while this runs.
  task automatic chk_disp(input string nm, input int m, input int s);
    int dv[4];
    dv[0] = s % 10; dv[1] = s / 10; dv[2] = m % 10; dv[3] = m / 10;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a_exp, prev;
      int         n;
      bit         seen;
      a_exp = ~(8'h01 << k);
      prev  = an;
      n     = 0;
      seen  = 1'b0;
      while (!seen && n < 24) begin
        @(negedge clock);
        n++;
        if (an == a_exp && prev != a_exp) seen = 1'b1;
        else prev = an;
      end
      if (!seen) begin
        tests++;
        fails++;
        $display("FAIL %s_d%0d: an stuck at %h, want a switch to %h", nm, k, an, a_exp);
      end else begin
        push_disp($sformatf("%s_d%0d", nm, k), a_exp, {SEG[dv[k]], (k != 2)});
      end
    end
    @(negedge clock);
  endtask

  task automatic chk_drain(input string nm);
    tests++;
    if (doneq.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d done pulse(s) missing, want 0", nm, doneq.size());
      doneq.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int s_cyc, r_cyc;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    min = 7'd0; sec = 7'd0;

    // Reset state, then first digit right after release.
    @(negedge clock);
    push_disp("reset", 8'hFF, 8'hFF);
    idle(3);
    reset = 1'b0;
    push_disp("first_digit", 8'hFE, 8'h03);
    chk_disp("post_reset", 0, 0);

    // 00:03 runs out: done exactly 30 cycles after start, one cycle wide.
    min = 7'd0; sec = 7'd3;
    idle(2);
    pulse(1'b1, 1'b0, 1'b0);
    s_cyc = cyc;
    doneq.push_back(s_cyc + 30);
    idle(35);
    chk_drain("a_done");
    sec = 7'd7;
    chk_disp("a_idle", 0, 7);

    // 02:00, one tick borrows to 01:59; pause (beats a same-cycle start),
    // presets ignored while paused, stop reloads them.
    min = 7'd2; sec = 7'd0;
    idle(2);
    pulse(1'b1, 1'b0, 1'b0);
    idle(11);
    pulse(1'b1, 1'b0, 1'b1);
    min = 7'd5; sec = 7'd5;
    chk_disp("b_0159", 1, 59);
    pulse(1'b0, 1'b1, 1'b0);
    chk_disp("b_reload", 5, 5);

    // Pause after 5 counted cycles, hold, resume: tick 5 cycles later.
    min = 7'd0; sec = 7'd1;
    idle(2);
    pulse(1'b1, 1'b0, 1'b0);
    idle(5);
    pulse(1'b0, 1'b0, 1'b1);
    idle(50);
    chk_disp("c_frozen", 0, 1);
    pulse(1'b0, 1'b0, 1'b1);
    r_cyc = cyc;
    doneq.push_back(r_cyc + 5);
    idle(10);
    chk_drain("c_done");

    // Saturation, then start with 00:00 stays IDLE.
    min = 7'd120; sec = 7'd75;
    idle(2);
    chk_disp("d_sat", 99, 59);
    min = 7'd0; sec = 7'd0;
    idle(2);
    pulse(1'b1, 1'b0, 1'b0);
    idle(30);
    sec = 7'd4;
    chk_disp("d_idle", 0, 4);

    // stop + pause together in RUN: stop wins.
    min = 7'd0; sec = 7'd5;
    idle(2);
    pulse(1'b1, 1'b0, 1'b0);
    idle(3);
    pulse(1'b0, 1'b1, 1'b1);
    sec = 7'd8;
    chk_disp("e_stop", 0, 8);
    idle(40);

    // Reset at 00:01 mid-RUN: blank display, no done, IDLE at 00:00.
    min = 7'd0; sec = 7'd2;
    idle(2);
    pulse(1'b1, 1'b0, 1'b0);
    idle(12);
    reset = 1'b1;
    push_disp("f_rst", 8'hFF, 8'hFF);
    min = 7'd0; sec = 7'd0;
    idle(3);
    reset = 1'b0;
    push_disp("f_first", 8'hFE, 8'h03);
    chk_disp("f_idle", 0, 0);
    idle(30);
    chk_drain("f_end");

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
